// File: rtl/tone_scheduler.sv
// Tone scheduler for the C4/E4/G4 sound demo.
// Arbitrates held manual note buttons against an 8-step built-in melody and
// drives one square-wave pin plus a one-hot note indicator. All outputs are
// registered and update together with the state register.
`timescale 1ns/1ps
module tone_scheduler #(
  parameter int clock_frequency = 12000000,
  parameter int tick_hz         = 100,
  parameter int gap_ticks       = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] manual_req,
  output logic       sound,
  output logic [2:0] note_active,
  output logic       busy,
  output logic       done,
  output logic [2:0] step
);

  localparam int TICK_CYCLES = clock_frequency / tick_hz;
  localparam int DIV_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_CYCLES - 1);
  localparam bit         HAS_GAP  = (gap_ticks != 0);
  localparam logic [7:0] GAP_LAST = 8'(gap_ticks - 1);

  localparam longint unsigned CLK_X100 = 64'(clock_frequency) * 64'd100;
  localparam logic [15:0] HALF_C = 16'((CLK_X100 / 64'd26163) / 64'd2);
  localparam logic [15:0] HALF_E = 16'((CLK_X100 / 64'd32963) / 64'd2);
  localparam logic [15:0] HALF_G = 16'((CLK_X100 / 64'd39200) / 64'd2);

  localparam logic [2:0] NOTE_C    = 3'b100;
  localparam logic [2:0] NOTE_E    = 3'b010;
  localparam logic [2:0] NOTE_G    = 3'b001;
  localparam logic [2:0] NOTE_REST = 3'b000;

  typedef enum logic [1:0] {IDLE, MANUAL, PLAY, GAP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [2:0]       note_q, note_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sound_q;
  logic [15:0]      phase_q;
  logic [15:0]      half_last;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       tick_q;
  logic             restart;
  logic             advance;
  logic             div_end;
  logic             play_end;
  logic             gap_end;
  logic [2:0]       manual_note;

  function automatic logic [2:0] rom_note(input logic [2:0] idx);
    case (idx)
      3'd0:    return NOTE_C;
      3'd1:    return NOTE_E;
      3'd2:    return NOTE_G;
      3'd3:    return NOTE_REST;
      3'd4:    return NOTE_G;
      3'd5:    return NOTE_E;
      3'd6:    return NOTE_C;
      default: return NOTE_REST;
    endcase
  endfunction

  function automatic logic [7:0] rom_ticks(input logic [2:0] idx);
    case (idx)
      3'd6:    return 8'd50;
      default: return 8'd25;
    endcase
  endfunction

  // Index of the final tick of a step; a zero-length entry plays one tick.
  function automatic logic [7:0] rom_last(input logic [2:0] idx);
    logic [7:0] t;
    t = rom_ticks(idx);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

  function automatic logic [2:0] priority_note(input logic [2:0] req);
    if (req[2])      return NOTE_C;
    else if (req[1]) return NOTE_E;
    else if (req[0]) return NOTE_G;
    else             return NOTE_REST;
  endfunction

  assign manual_note = priority_note(manual_req);
  assign div_end     = (div_q == DIV_LAST);
  assign play_end    = div_end && (tick_q == rom_last(step_q));
  assign gap_end     = div_end && (tick_q == GAP_LAST);

  // Next-state and next-output decision; preemption is checked before timing.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    note_d  = NOTE_REST;
    done_d  = 1'b0;
    restart = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (|manual_req) begin
          state_d = MANUAL;
          note_d  = manual_note;
        end else if (start) begin
          state_d = PLAY;
          step_d  = '0;
          note_d  = rom_note(3'd0);
          restart = 1'b1;
        end
      end
      MANUAL: begin
        if (|manual_req) note_d = manual_note;
        else             state_d = IDLE;
      end
      PLAY, GAP: begin
        if (|manual_req) begin
          state_d = MANUAL;
          note_d  = manual_note;
          step_d  = '0;
        end else if (stop) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (state_q == PLAY) begin
          if (!play_end) begin
            note_d = rom_note(step_q);
          end else if (HAS_GAP) begin
            state_d = GAP;
            restart = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end else if (gap_end) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Shared end-of-step handling for both the PLAY (no gap) and GAP exits.
    if (advance) begin
      if (step_q == 3'd7) begin
        state_d = IDLE;
        step_d  = '0;
        done_d  = 1'b1;
      end else begin
        state_d = PLAY;
        step_d  = step_q + 3'd1;
        note_d  = rom_note(step_q + 3'd1);
        restart = 1'b1;
      end
    end
    busy_d = (state_d == PLAY) || (state_d == GAP);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      note_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      note_q  <= note_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Tick prescaler and tick counter; cleared on every PLAY/GAP entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= '0;
    end else if (restart || !busy_d) begin
      div_q  <= '0;
      tick_q <= '0;
    end else if (div_end) begin
      div_q  <= '0;
      tick_q <= tick_q + 8'd1;
    end else begin
      div_q  <= div_q + 1'b1;
    end
  end

  // Half-period lookup for the note currently sounding.
  always_comb begin
    case (note_q)
      NOTE_C:  half_last = HALF_C - 16'd1;
      NOTE_E:  half_last = HALF_E - 16'd1;
      NOTE_G:  half_last = HALF_G - 16'd1;
      default: half_last = '0;
    endcase
  end

  // Square-wave generator; a note change restarts the phase with sound low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      sound_q <= 1'b0;
    end else if (note_d != note_q || note_q == NOTE_REST) begin
      phase_q <= '0;
      sound_q <= 1'b0;
    end else if (phase_q == half_last) begin
      phase_q <= '0;
      sound_q <= ~sound_q;
    end else begin
      phase_q <= phase_q + 16'd1;
    end
  end

  assign sound       = sound_q;
  assign note_active = note_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign step        = step_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: directed scenario sequence with randomized hold
// times and abort points, checked every cycle against a timeline model built
// from the melody table and the half-period formula.
`timescale 1ns/1ps
module tb_tone_scheduler;

  localparam int CLK_HZ  = 12000000;
  // Tick rate raised so the whole melody stays short; durations scale with it.
  localparam int TICK_HZ = 1200000;
  localparam int GAP_T   = 2;
  localparam int TICK    = CLK_HZ / TICK_HZ;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] manual_req = 3'b000;
  logic       sound;
  logic [2:0] note_active;
  logic       busy;
  logic       done;
  logic [2:0] step;

  tone_scheduler #(
    .clock_frequency(CLK_HZ),
    .tick_hz        (TICK_HZ),
    .gap_ticks      (GAP_T)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .manual_req (manual_req),
    .sound      (sound),
    .note_active(note_active),
    .busy       (busy),
    .done       (done),
    .step       (step)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [2:0] rom_note_tab [8] = '{3'b100, 3'b010, 3'b001, 3'b000,
                                   3'b001, 3'b010, 3'b100, 3'b000};
  int         rom_ticks_tab [8] = '{25, 25, 25, 25, 25, 25, 50, 25};

  logic [2:0] exp_note = 3'b000;
  logic [2:0] exp_step = 3'b000;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic       exp_sound = 1'b0;
  logic [2:0] prev_note = 3'b000;
  int         since = 0;
  string      tag = "reset";

  function automatic int half_of(input logic [2:0] n);
    longint f;
    case (n)
      3'b100:  f = 26163;
      3'b010:  f = 32963;
      default: f = 39200;
    endcase
    return int'((longint'(CLK_HZ) * 100 / f) / 2);
  endfunction

  function automatic logic [2:0] prio(input logic [2:0] r);
    if (r[2])      return 3'b100;
    else if (r[1]) return 3'b010;
    else if (r[0]) return 3'b001;
    return 3'b000;
  endfunction

  task automatic check_vec(input string name, input logic [8:0] obs, input logic [8:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s t=%0t observed={snd,note,busy,done,step}=%b expected=%b", name, $time, obs, expv);
    end
  endtask

  task automatic set_exp(input logic [2:0] n, input logic b, input logic d, input logic [2:0] s);
    exp_note = n;
    exp_busy = b;
    exp_done = d;
    exp_step = s;
  endtask

  // Advance one clock and compare all outputs with the model for that cycle.
  task automatic step_cycle();
    @(posedge clock);
    #1;
    if (exp_note != prev_note) since = 0;
    else if (exp_note != 3'b000) since++;
    prev_note = exp_note;
    exp_sound = (exp_note != 3'b000) && (((since / half_of(exp_note)) % 2) == 1);
    check_vec(tag, {sound, note_active, busy, done, step},
              {exp_sound, exp_note, exp_busy, exp_done, exp_step});
  endtask

  task automatic hold(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic do_abort(input int kind);
    if (kind == 1) begin
      tag = "abort_stop";
      stop = 1'b1;
      set_exp(3'b000, 1'b0, 1'b0, 3'd0);
      step_cycle();
      stop = 1'b0;
      hold($urandom_range(3, 20));
    end else if (kind == 2) begin
      tag = "abort_manual";
      manual_req = 3'b010;
      set_exp(3'b010, 1'b0, 1'b0, 3'd0);
      hold($urandom_range(5, 200));
      manual_req = 3'b000;
      set_exp(3'b000, 1'b0, 1'b0, 3'd0);
      hold(3);
    end else begin
      tag = "async_reset";
      #2;
      reset_n = 1'b0;
      #1;
      check_vec("async_reset_now", {sound, note_active, busy, done, step}, 9'b0);
      set_exp(3'b000, 1'b0, 1'b0, 3'd0);
      prev_note = 3'b000;
      since = 0;
      hold(3);
      reset_n = 1'b1;
      hold(5);
    end
  endtask

  // Plays the melody from a start pulse; kind 0 runs to completion,
  // otherwise aborts after cycle ab_off of step ab_step.
  task automatic run_melody(input int ab_step, input int ab_off, input int kind);
    int dur;
    start = 1'b1;
    for (int s = 0; s < 8; s++) begin
      tag = $sformatf("melody_step%0d", s);
      dur = ((rom_ticks_tab[s] == 0) ? 1 : rom_ticks_tab[s]) * TICK;
      set_exp(rom_note_tab[s], 1'b1, 1'b0, 3'(s));
      for (int c = 0; c < dur; c++) begin
        step_cycle();
        start = 1'b0;
        if (kind != 0 && s == ab_step && c == ab_off) begin
          do_abort(kind);
          return;
        end
      end
      tag = $sformatf("melody_gap%0d", s);
      set_exp(3'b000, 1'b1, 1'b0, 3'(s));
      repeat (GAP_T * TICK) step_cycle();
    end
    tag = "melody_done";
    set_exp(3'b000, 1'b0, 1'b1, 3'd0);
    step_cycle();
    set_exp(3'b000, 1'b0, 1'b0, 3'd0);
    step_cycle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [2:0] pat;

    // Reset state.
    tag = "reset";
    set_exp(3'b000, 1'b0, 1'b0, 3'd0);
    hold(3);
    reset_n = 1'b1;
    hold(5);

    // Held C: one full half period of tone, then release.
    tag = "manual_C";
    manual_req = 3'b100;
    set_exp(3'b100, 1'b0, 1'b0, 3'd0);
    hold(half_of(3'b100) + $urandom_range(1, 200));
    tag = "manual_C_release";
    manual_req = 3'b000;
    set_exp(3'b000, 1'b0, 1'b0, 3'd0);
    hold(3);

    // E+G held: E wins; dropping E falls back to G with a fresh phase.
    tag = "manual_EG";
    manual_req = 3'b011;
    set_exp(3'b010, 1'b0, 1'b0, 3'd0);
    hold(half_of(3'b010) + $urandom_range(1, 100));
    tag = "manual_G";
    manual_req = 3'b001;
    set_exp(3'b001, 1'b0, 1'b0, 3'd0);
    hold($urandom_range(50, 300));
    manual_req = 3'b000;
    set_exp(3'b000, 1'b0, 1'b0, 3'd0);
    hold(3);

    // Full melody.
    run_melody(0, 0, 0);
    tag = "after_melody";
    hold(5);

    // Simultaneous start and manual request: manual wins, melody never starts.
    tag = "start_vs_manual";
    start = 1'b1;
    manual_req = 3'b001;
    set_exp(3'b001, 1'b0, 1'b0, 3'd0);
    step_cycle();
    start = 1'b0;
    hold($urandom_range(2, 40));
    manual_req = 3'b000;
    set_exp(3'b000, 1'b0, 1'b0, 3'd0);
    hold($urandom_range(20, 60));

    // Random button patterns; start only offered while a button is held.
    tag = "random_manual";
    for (int i = 0; i < 40; i++) begin
      pat = 3'($urandom_range(0, 7));
      manual_req = pat;
      start = (pat != 3'b000) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop = 1'($urandom_range(0, 1));
      set_exp(prio(pat), 1'b0, 1'b0, 3'd0);
      step_cycle();
      start = 1'b0;
      hold($urandom_range(0, 30));
    end
    manual_req = 3'b000;
    stop = 1'b0;
    set_exp(3'b000, 1'b0, 1'b0, 3'd0);
    hold(2);

    // Aborts during step 4 by stop and by a manual button.
    run_melody(4, $urandom_range(0, 25 * TICK - 1), 1);
    run_melody(4, $urandom_range(0, 25 * TICK - 1), 2);

    // Asynchronous reset during step 2, then a full replay.
    run_melody(2, $urandom_range(0, 25 * TICK - 1), 3);
    run_melody(0, 0, 0);
    tag = "final_idle";
    hold(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
